uart_top: RTL and testbench
===========================

# uart_top

Self-contained UART loopback block: an 8-bit transmitter serialises a byte and an internal receiver deserialises it from the same line. It checks optional even parity and the stop bit. It sits at the top of the UART subsystem as the integration and verification vehicle for the TX and RX datapaths. It runs from a single 50 MHz clock at 9600 baud, 8 data bits, LSB first, optional even parity and 1 stop bit.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (= 5208): clock cycles per serial bit.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- transmit  in  1  transmit request; a rising edge starts one frame.
- TX_DATA  in  8  byte to send; latched at frame start.
- par_EN  in  1  1 = append/check even parity bit; 0 = no parity bit.
- busy  out  1  high while the transmitter is sending a frame.
- RXDATA  out  8  last received byte.
- VALID_RX  out  1  last frame received with correct parity (if enabled) and stop = 1.
- PARITY_ERROR  out  1  last frame had a parity mismatch.
- STOP_ERROR  out  1  last frame had its stop bit sampled low.

## Operation
- Internal serial line: the TX output drives the RX input directly. The line idles high.
- Reset (RST = 0): line = 1, busy = 0, RXDATA = 0, VALID_RX = 0, PARITY_ERROR = 0, STOP_ERROR = 0. Both FSMs go to IDLE and all counters clear.
- TX FSM states: IDLE → START → DATA (8 bits, bit 0 first) → PARITY (only if par_EN) → STOP → IDLE.
  - A frame starts on a rising edge of transmit. The edge is detected with a registered copy of transmit.
  - Holding transmit high sends exactly one frame.
  - Edges while busy are ignored.
  - TX_DATA and par_EN are latched at frame start.
  - The parity bit is the XOR of the 8 data bits (even parity).
- RX FSM states: IDLE → START → DATA → PARITY (if par_EN) → STOP → IDLE.
  - A falling edge on the line moves RX from IDLE to START.
  - The start bit is re-checked at mid-bit (CLKS_PER_BIT/2 = 2604 cycles). If the line is high there, it is treated as a glitch: return to IDLE with flags unchanged.
  - On a valid start bit, clear VALID_RX, PARITY_ERROR and STOP_ERROR, and latch par_EN.
  - Data bits are sampled at the middle of each bit, shifted in LSB first.
  - At the stop-bit mid-sample:
    - RXDATA = shifted byte.
    - PARITY_ERROR = par_EN and (XOR(data) ≠ received parity bit).
    - STOP_ERROR = (stop sample == 0).
    - VALID_RX = neither error.
  - All RX outputs hold their values until the next valid start bit or reset.

## Timing
- Bit period: exactly CLKS_PER_BIT cycles, set by a per-FSM counter that counts 0..CLKS_PER_BIT-1.
- TX start latency:
  - The transmit edge is sampled at clock edge N.
  - The line goes low and busy goes high at edge N+1.
- TX frame length: 11 bit periods with parity, 10 without.
- busy falls at the end of the stop-bit period, in the same cycle the line returns to IDLE.
- RX outputs update:
  - With parity: 10.5 bit periods after the start bit's falling edge.
  - Without parity: 9.5 bit periods after the start bit's falling edge.
  - In both cases the update lands well inside 12 bit periods, about 1.25 ms at default parameters.
- Reset mid-frame: immediate abort. The line returns high, all outputs take their reset values, and no partial byte is reported.
- A new transmit edge in the cycle busy falls is accepted on the following cycle.

## Structure
- Package uart_pkg holds:
  - CLKS_PER_BIT default and its counter width ($clog2).
  - The shared frame-state enum (IDLE, START, DATA, PARITY, STOP).
  - The data width constant (8).
- Natural sub-modules, each with its own counter and FSM:
  - uart_tx: edge detect, shift register, parity generator.
  - uart_rx: mid-bit sampler, shift register, parity/stop checker.
- uart_top only wires the two together and exposes the ports.

## Test plan
- Reset, par_EN = 1, TX_DATA = 8'hAA, pulse transmit high for 12 bit periods → busy high for 11 bit periods; RXDATA = 8'hAA, VALID_RX = 1, PARITY_ERROR = 0, STOP_ERROR = 0.
- par_EN = 0, TX_DATA = 8'h0F, then 8'hFF, then 8'h00, one frame each → each byte received exactly, VALID_RX = 1, no errors, busy high 10 bit periods.
- par_EN = 1 with 8'h01, 8'h80, 8'hF7, 8'h55, 8'h3C → exact byte recovered; confirms LSB-first order; parity bit on the line equals XOR(data); VALID_RX = 1.
- Hold transmit high continuously for 30 bit periods → exactly one frame sent; the line stays idle high after the stop bit.
- Assert RST low mid-data-bit of a frame → all outputs return to reset values immediately; the next frame with 8'hF0 is received correctly.
- Force the RX line low during the stop bit, and separately flip the parity bit → STOP_ERROR = 1, VALID_RX = 0; then PARITY_ERROR = 1, VALID_RX = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame widths, default bit timing and the frame-state
// encoding used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 50_000_000 / 9600;
    localparam int CNT_W_DEF        = $clog2(CLKS_PER_BIT_DEF);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampler with start-glitch rejection; results land at the stop-bit mid-sample
// and hold until the next valid start bit. No backpressure: every frame overwrites the result registers.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_line,
    input  logic              i_par_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_par_err,
    output logic              o_stop_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    frame_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]        r_bit_idx, w_bit_idx_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par_en, w_par_en_nxt;
    logic              r_par_bit, w_par_bit_nxt;
    logic              r_line_d;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_perr, w_perr_nxt;
    logic              r_serr, w_serr_nxt;
    logic              w_fall;
    logic              w_bit_end;
    logic              w_par_mis;

    assign w_fall     = r_line_d & ~i_line;
    assign w_bit_end  = (r_cnt == LAST_CNT);
    assign w_par_mis  = r_par_en & (even_parity(r_shift) ^ r_par_bit);
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_par_err  = r_perr;
    assign o_stop_err = r_serr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_line_d  <= 1'b1;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_serr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_line_d  <= i_line;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_perr    <= w_perr_nxt;
            r_serr    <= w_serr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_perr_nxt    = r_perr;
        w_serr_nxt    = r_serr;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // A line that is high again at mid-start was noise; keep the previous result.
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt = '0;
                    if (i_line) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                        w_par_en_nxt  = i_par_en;
                        w_valid_nxt   = 1'b0;
                        w_perr_nxt    = 1'b0;
                        w_serr_nxt    = 1'b0;
                    end
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {i_line, r_shift[DATA_W-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_par_bit_nxt = i_line;
                    w_state_nxt   = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_data_nxt  = r_shift;
                    w_perr_nxt  = w_par_mis;
                    w_serr_nxt  = ~i_line;
                    w_valid_nxt = ~w_par_mis & i_line;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: a registered rising edge of i_transmit starts one frame; line drops and busy rises
// two cycles after transmit goes high. Requests while a frame is in flight are ignored (no queueing).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_transmit,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par_en,
    output logic              o_line,
    output logic              o_busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    frame_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]        r_bit_idx, w_bit_idx_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par_en, w_par_en_nxt;
    logic              r_parity, w_parity_nxt;
    logic              r_line, w_line_nxt;
    logic              r_tx_s, r_tx_d;
    logic              w_rise;
    logic              w_bit_end;

    assign w_rise    = r_tx_s & ~r_tx_d;
    assign w_bit_end = (r_cnt == LAST_CNT);
    assign o_line    = r_line;
    assign o_busy    = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_parity  <= 1'b0;
            r_line    <= 1'b1;
            r_tx_s    <= 1'b0;
            r_tx_d    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_parity  <= w_parity_nxt;
            r_line    <= w_line_nxt;
            r_tx_s    <= i_transmit;
            r_tx_d    <= r_tx_s;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_parity_nxt  = r_parity;
        w_line_nxt    = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt   = START;
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_shift_nxt   = i_data;
                    w_par_en_nxt  = i_par_en;
                    w_parity_nxt  = even_parity(i_data);
                end
            end
            START: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end
            end
            DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = '0;
                end
            end
            STOP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Line level is registered from the next state so it changes glitch-free with busy.
        case (w_state_nxt)
            START:   w_line_nxt = 1'b0;
            DATA:    w_line_nxt = w_shift_nxt[0];
            PARITY:  w_line_nxt = r_parity;
            default: w_line_nxt = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_top.sv
// UART loopback: transmitter output drives receiver input on an internal idle-high line.
// Receive result appears ~10.5 (parity) / 9.5 bit periods after the start edge; new requests wait for busy low.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              transmit,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              par_EN,
    output logic              busy,
    output logic [DATA_W-1:0] RXDATA,
    output logic              VALID_RX,
    output logic              PARITY_ERROR,
    output logic              STOP_ERROR
);

    logic w_line;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_transmit (transmit),
        .i_data     (TX_DATA),
        .i_par_en   (par_EN),
        .o_line     (w_line),
        .o_busy     (busy)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_line     (w_line),
        .i_par_en   (par_EN),
        .o_data     (RXDATA),
        .o_valid    (VALID_RX),
        .o_par_err  (PARITY_ERROR),
        .o_stop_err (STOP_ERROR)
    );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top with a short bit period so whole frames fit in a few hundred cycles.
module tb_uart_top;

    localparam int CPB = 16;

    logic       CLK;
    logic       RST;
    logic       transmit;
    logic [7:0] TX_DATA;
    logic       par_EN;
    logic       busy;
    logic [7:0] RXDATA;
    logic       VALID_RX;
    logic       PARITY_ERROR;
    logic       STOP_ERROR;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         hold;
        int         fkind;     // 0 none, 1 invert parity bit, 2 stop bit low
        int         exp_busy;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[13];

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .transmit     (transmit),
        .TX_DATA      (TX_DATA),
        .par_EN       (par_EN),
        .busy         (busy),
        .RXDATA       (RXDATA),
        .VALID_RX     (VALID_RX),
        .PARITY_ERROR (PARITY_ERROR),
        .STOP_ERROR   (STOP_ERROR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int          t0, busy_cnt, rises, idle_low, upd_rel, stop_idx, total, rel, lo, hi;
        logic        prev_busy;
        logic [10:0] line_bits, exp_bits;
        stop_idx = v.p ? 10 : 9;
        exp_bits = '0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = v.d[i];
        if (v.p) exp_bits[9] = ^v.d;
        exp_bits[stop_idx] = 1'b1;
        if (v.fkind == 1) exp_bits[9] = ~exp_bits[9];
        if (v.fkind == 2) exp_bits[stop_idx] = 1'b0;

        t0 = -1; busy_cnt = 0; rises = 0; idle_low = 0; upd_rel = -1;
        prev_busy = 1'b0; line_bits = '0;
        total = v.hold + 13 * CPB;
        @(negedge CLK);
        TX_DATA  = v.d;
        par_EN   = v.p;
        transmit = 1'b1;
        for (int cyc = 1; cyc <= total; cyc++) begin
            @(posedge CLK);
            #1;
            if (cyc == v.hold) transmit = 1'b0;
            if (busy && !prev_busy) begin
                rises++;
                if (t0 < 0) t0 = cyc;
            end
            prev_busy = busy;
            if (busy) busy_cnt++;
            if (t0 >= 0) begin
                rel = cyc - t0;
                if (rel < (stop_idx + 1) * CPB && (rel % CPB) == CPB / 2)
                    line_bits[rel / CPB] = dut.w_line;
                if (rel > 11 * CPB && dut.w_line !== 1'b1) idle_low++;
                if (rel > CPB && upd_rel < 0 && (VALID_RX | PARITY_ERROR | STOP_ERROR))
                    upd_rel = rel;
                if (v.fkind == 1 && rel == 9 * CPB + 4) begin
                    if (exp_bits[9]) force dut.w_line = 1'b1;
                    else             force dut.w_line = 1'b0;
                end
                if (v.fkind == 2 && rel == stop_idx * CPB + 4) force dut.w_line = 1'b0;
                if (v.fkind == 1 && rel == 9 * CPB + 12) release dut.w_line;
                if (v.fkind == 2 && rel == stop_idx * CPB + 12) release dut.w_line;
            end
        end
        lo = stop_idx * CPB + CPB / 2 - 2;
        hi = stop_idx * CPB + CPB / 2 + 3;
        chk("start_latency", t0, 2);
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("frame_count", rises, 1);
        chk("line_bits", {21'd0, line_bits}, {21'd0, exp_bits});
        chk("idle_after_stop", idle_low, 0);
        chk("rx_update_window", {31'd0, (upd_rel >= lo && upd_rel <= hi)}, 1);
        chk("RXDATA", {24'd0, RXDATA}, {24'd0, v.exp_data});
        chk("VALID_RX", {31'd0, VALID_RX}, {31'd0, v.exp_valid});
        chk("PARITY_ERROR", {31'd0, PARITY_ERROR}, {31'd0, v.exp_perr});
        chk("STOP_ERROR", {31'd0, STOP_ERROR}, {31'd0, v.exp_serr});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_line"}, {31'd0, dut.w_line}, 1);
        chk({tag, "_RXDATA"}, {24'd0, RXDATA}, 0);
        chk({tag, "_VALID_RX"}, {31'd0, VALID_RX}, 0);
        chk({tag, "_PARITY_ERROR"}, {31'd0, PARITY_ERROR}, 0);
        chk({tag, "_STOP_ERROR"}, {31'd0, STOP_ERROR}, 0);
    endtask

    initial begin
        vecs[0]  = '{8'hAA, 1'b1, 12 * CPB, 0, 176, 8'hAA, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h0F, 1'b0, 4,        0, 160, 8'h0F, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 1'b0, 4,        0, 160, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 4,        0, 160, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'h01, 1'b1, 4,        0, 176, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h80, 1'b1, 4,        0, 176, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'hF7, 1'b1, 4,        0, 176, 8'hF7, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h55, 1'b1, 4,        0, 176, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h3C, 1'b1, 4,        0, 176, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'hC3, 1'b1, 30 * CPB, 0, 176, 8'hC3, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'h96, 1'b1, 4,        2, 176, 8'h96, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'h69, 1'b0, 4,        2, 160, 8'h69, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{8'h96, 1'b1, 4,        1, 176, 8'h96, 1'b0, 1'b1, 1'b0};

        RST = 1'b1; transmit = 1'b0; TX_DATA = 8'h00; par_EN = 1'b0;
        #3 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        for (int i = 0; i < 13; i++) apply(vecs[i]);

        // Short low pulse on an idle line must not disturb the held result.
        @(negedge CLK);
        force dut.w_line = 1'b0;
        repeat (3) @(negedge CLK);
        release dut.w_line;
        repeat (3 * CPB) @(negedge CLK);
        chk("glitch_RXDATA", {24'd0, RXDATA}, {24'd0, vecs[12].exp_data});
        chk("glitch_VALID_RX", {31'd0, VALID_RX}, {31'd0, vecs[12].exp_valid});
        chk("glitch_PARITY_ERROR", {31'd0, PARITY_ERROR}, {31'd0, vecs[12].exp_perr});
        chk("glitch_busy", {31'd0, busy}, 0);

        // Reset in the middle of a data bit aborts the frame outright.
        @(negedge CLK);
        TX_DATA = 8'h3C; par_EN = 1'b1; transmit = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge CLK);
        chk("busy_before_abort", {31'd0, busy}, 1);
        RST = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (4) @(negedge CLK);
        transmit = 1'b0;
        RST = 1'b1;
        repeat (14 * CPB) @(negedge CLK);
        chk_reset_outputs("post_abort");

        apply('{8'hF0, 1'b1, 4, 0, 176, 8'hF0, 1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
